sa_result_packer: RTL and testbench

Sits between the systolic array output drain and dma_write. It takes one signed accumulator result per handshake and requantizes it to int8 by rounding, arithmetic right shift and saturation. It packs four consecutive int8 results into one 32-bit word and buffers the words in a first-word-fall-through FIFO. dma_write pops that FIFO with its o_ready pulses, and this block reports per-tile word and byte counts for dma_write's i_byte_len.

---
 rtl/sa_result_packer_if.sv | 39 +++
 rtl/sa_result_packer.sv | 184 ++++++++++++++++++
 tb/tb_sa_result_packer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sa_result_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : sa_result_packer_if
// Brief    : Accumulator-result input and packed-word output bundle for the
//            systolic-array result packer.
// Revision : 1.0
// ============================================================================
interface sa_result_packer_if #(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                        i_clear;
    logic [4:0]                  i_shift;
    logic signed [ACC_WIDTH-1:0] i_acc_data;
    logic                        i_acc_valid;
    logic                        i_acc_last;
    logic                        o_acc_ready;
    logic [DATA_WIDTH-1:0]       o_data;
    logic                        o_valid;
    logic                        i_ready;
    logic                        o_tile_done;
    logic [CNT_WIDTH+1:0]        o_tile_bytes;
    logic                        o_overflow;
    logic                        o_underflow;

    modport slave (
        input  i_clear, i_shift, i_acc_data, i_acc_valid, i_acc_last, i_ready,
        output o_acc_ready, o_data, o_valid, o_tile_done, o_tile_bytes,
               o_overflow, o_underflow
    );

    modport master (
        output i_clear, i_shift, i_acc_data, i_acc_valid, i_acc_last, i_ready,
        input  o_acc_ready, o_data, o_valid, o_tile_done, o_tile_bytes,
               o_overflow, o_underflow
    );
endinterface
`default_nettype wire

// File: rtl/sa_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : sa_result_packer
// Brief    : Requantizes accumulator results to int8, packs four per 32-bit
//            word into a FWFT FIFO and reports per-tile byte counts.
// Revision : 1.0
// ============================================================================
module sa_result_packer #(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic           ACLK,
    input  wire logic           ARESET,
    sa_result_packer_if.slave   bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic signed [ACC_WIDTH:0] c_SAT_HI = (ACC_WIDTH+1)'(127);
    localparam logic signed [ACC_WIDTH:0] c_SAT_LO = (ACC_WIDTH+1)'(-128);

    typedef enum logic [0:0] {
        PK_COLLECT = 1'b0,
        PK_FLUSH   = 1'b1
    } pk_state_t;

    pk_state_t              r_state;
    logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_rd_ptr, r_wr_ptr;
    logic [c_PTR_W:0]       r_count;
    logic [DATA_WIDTH-1:0]  r_last_pop;
    logic                   r_s1_valid, r_s1_last;
    logic [7:0]             r_s1_byte;
    logic [1:0]             r_idx;
    logic [DATA_WIDTH-1:0]  r_pack;
    logic                   r_wr_en, r_wr_last;
    logic [DATA_WIDTH-1:0]  r_wr_data;
    logic [CNT_WIDTH-1:0]   r_tile_cnt;
    logic                   r_tile_done;
    logic [CNT_WIDTH+1:0]   r_tile_bytes;
    logic                   r_overflow, r_underflow;

    logic                   w_empty, w_full, w_acc_ready, w_accept, w_pop, w_push;
    logic signed [ACC_WIDTH:0] w_round, w_sum, w_q;
    logic [7:0]             w_sat;
    logic [DATA_WIDTH-1:0]  w_word;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == (c_PTR_W+1)'(FIFO_DEPTH));
    // Two free entries are kept in reserve for results already in the pipeline.
    assign w_acc_ready = !ARESET && !bus.i_clear && (r_state == PK_COLLECT)
                         && (r_count < (c_PTR_W+1)'(FIFO_DEPTH - 2));
    assign w_accept    = bus.i_acc_valid && w_acc_ready;
    assign w_pop       = bus.i_ready && !w_empty;
    assign w_push      = r_wr_en && (!w_full || w_pop);
    assign w_cnt_inc   = (r_tile_cnt == '1) ? r_tile_cnt : r_tile_cnt + 1'b1;

    always_comb begin
        w_round = '0;
        if (bus.i_shift != 5'd0)
            w_round = (ACC_WIDTH+1)'(1) << (bus.i_shift - 5'd1);
        w_sum = {bus.i_acc_data[ACC_WIDTH-1], bus.i_acc_data} + w_round;
        w_q   = w_sum >>> bus.i_shift;
        if (w_q > c_SAT_HI)
            w_sat = 8'h7F;
        else if (w_q < c_SAT_LO)
            w_sat = 8'h80;
        else
            w_sat = w_q[7:0];
    end

    always_comb begin
        w_word = r_pack;
        w_word[{r_idx, 3'b000} +: 8] = r_s1_byte;
    end

    always_ff @(posedge ACLK) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_wr_data;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state      <= PK_COLLECT;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_last_pop   <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_byte    <= '0;
            r_idx        <= '0;
            r_pack       <= '0;
            r_wr_en      <= 1'b0;
            r_wr_last    <= 1'b0;
            r_wr_data    <= '0;
            r_tile_cnt   <= '0;
            r_tile_done  <= 1'b0;
            r_tile_bytes <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (bus.i_clear) begin
            r_state      <= PK_COLLECT;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_last_pop   <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_byte    <= '0;
            r_idx        <= '0;
            r_pack       <= '0;
            r_wr_en      <= 1'b0;
            r_wr_last    <= 1'b0;
            r_wr_data    <= '0;
            r_tile_cnt   <= '0;
            r_tile_done  <= 1'b0;
            r_tile_bytes <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_byte <= w_sat;
                r_s1_last <= bus.i_acc_last;
            end

            r_wr_en <= 1'b0;
            if (r_s1_valid) begin
                if ((r_idx == 2'd3) || r_s1_last) begin
                    r_wr_en   <= 1'b1;
                    r_wr_data <= w_word;
                    r_wr_last <= r_s1_last;
                    r_pack    <= '0;
                    r_idx     <= '0;
                end else begin
                    r_pack <= w_word;
                    r_idx  <= r_idx + 2'd1;
                end
            end

            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_last_pop <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (r_wr_en && w_full && !w_pop)
                r_overflow <= 1'b1;
            if (bus.i_ready && w_empty)
                r_underflow <= 1'b1;

            r_tile_done <= 1'b0;
            if (r_wr_en && r_wr_last) begin
                r_tile_done  <= 1'b1;
                r_tile_bytes <= {w_cnt_inc, 2'b00};
                r_tile_cnt   <= '0;
            end else if (w_push && (r_tile_cnt != '1)) begin
                r_tile_cnt <= r_tile_cnt + 1'b1;
            end

            case (r_state)
                PK_COLLECT: if (w_accept && bus.i_acc_last) r_state <= PK_FLUSH;
                PK_FLUSH:   if (r_wr_en && r_wr_last)       r_state <= PK_COLLECT;
                default:    r_state <= PK_COLLECT;
            endcase
        end
    end

    assign bus.o_acc_ready  = w_acc_ready;
    assign bus.o_data       = w_empty ? r_last_pop : r_mem[r_rd_ptr];
    assign bus.o_valid      = !w_empty;
    assign bus.o_tile_done  = r_tile_done;
    assign bus.o_tile_bytes = r_tile_bytes;
    assign bus.o_overflow   = r_overflow;
    assign bus.o_underflow  = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_sa_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_result_packer
// Brief    : Directed self-checking bench for sa_result_packer (FIFO_DEPTH=8).
// Revision : 1.0
// ============================================================================
module tb_sa_result_packer;
    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    int   tile_pulses = 0;

    sa_result_packer_if #(.ACC_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();

    sa_result_packer #(
        .ACC_WIDTH (32),
        .DATA_WIDTH(32),
        .FIFO_DEPTH(8),
        .CNT_WIDTH (16)
    ) dut (
        .ACLK  (clk),
        .ARESET(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.o_tile_done) tile_pulses++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic [4:0] sh);
        int n = 0;
        @(negedge clk);
        while (!bus.o_acc_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 64'd1, 64'd0);
        bus.i_acc_valid = 1'b1;
        bus.i_acc_data  = d;
        bus.i_acc_last  = l;
        bus.i_shift     = sh;
        @(posedge clk);
        #1;
        bus.i_acc_valid = 1'b0;
        bus.i_acc_last  = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        while (!bus.o_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(bus.o_data), 64'(exp));
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
    endtask

    initial begin
        int p0;
        int j;
        int popped;
        logic acc_now;
        logic [31:0] ew;

        rst = 1'b1;
        bus.i_clear = 1'b0;
        bus.i_shift = '0;
        bus.i_acc_data = '0;
        bus.i_acc_valid = 1'b0;
        bus.i_acc_last = 1'b0;
        bus.i_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready",  64'(bus.o_acc_ready),  64'd0);
        check("rst_valid",  64'(bus.o_valid),      64'd0);
        check("rst_data",   64'(bus.o_data),       64'd0);
        check("rst_bytes",  64'(bus.o_tile_bytes), 64'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(bus.o_acc_ready), 64'd1);
        check("rst_flags", 64'({bus.o_overflow, bus.o_underflow, bus.o_tile_done}), 64'd0);

        // Shift 0 packing and three-cycle latency
        send(32'd1, 1'b0, 5'd0);
        send(32'd2, 1'b0, 5'd0);
        send(32'd3, 1'b0, 5'd0);
        send(32'd4, 1'b0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        check("lat_not_yet", 64'(bus.o_valid), 64'd0);
        @(negedge clk);
        check("lat_valid", 64'(bus.o_valid), 64'd1);
        pop_check("word_1234", 32'h0403_0201);

        // Rounding and saturation at shift 4
        send(32'd24,         1'b0, 5'd4);
        send(32'd23,         1'b0, 5'd4);
        send(32'hFFFF_FFE8,  1'b0, 5'd4);
        send(32'd5000,       1'b0, 5'd4);
        pop_check("word_round_sat", 32'h7FFF_0102);

        // Partial tile of six results
        pulse_clear();
        check("clear_bytes", 64'(bus.o_tile_bytes), 64'd0);
        p0 = tile_pulses;
        for (int k = 1; k <= 6; k++) send(32'(k), (k == 6), 5'd0);
        pop_check("tile_w0", 32'h0403_0201);
        pop_check("tile_w1", 32'h0000_0605);
        repeat (2) @(negedge clk);
        check("tile_pulses", 64'(tile_pulses - p0), 64'd1);
        check("tile_bytes",  64'(bus.o_tile_bytes), 64'd8);
        check("ready_back",  64'(bus.o_acc_ready),  64'd1);
        check("hold_data",   64'({bus.o_valid, bus.o_data}), 64'h0_0000_0605);

        // Pop request while empty
        @(negedge clk);
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        check("underflow_set", 64'(bus.o_underflow), 64'd1);
        check("no_pop_data",   64'(bus.o_data), 64'h0000_0605);
        pulse_clear();
        check("underflow_clr", 64'(bus.o_underflow), 64'd0);
        check("clear_data",    64'(bus.o_data), 64'd0);

        // Backpressure: 64 results, no pops for 40 cycles, then drain
        p0 = tile_pulses;
        j = 1;
        popped = 0;
        for (int cyc = 0; cyc < 400 && popped < 16; cyc++) begin
            @(negedge clk);
            bus.i_ready = (cyc >= 40) && bus.o_valid;
            if (j <= 64) begin
                bus.i_acc_valid = 1'b1;
                bus.i_acc_data  = 32'(j);
                bus.i_acc_last  = (j == 64);
                bus.i_shift     = 5'd0;
            end else begin
                bus.i_acc_valid = 1'b0;
                bus.i_acc_last  = 1'b0;
            end
            acc_now = bus.i_acc_valid && bus.o_acc_ready;
            if (cyc == 39) begin
                check("stall_accepted", 64'(j - 1), 64'd26);
                check("stall_ready",    64'(bus.o_acc_ready), 64'd0);
                check("stall_no_ovf",   64'(bus.o_overflow), 64'd0);
            end
            if (bus.i_ready) begin
                ew = {8'(4*popped+4), 8'(4*popped+3), 8'(4*popped+2), 8'(4*popped+1)};
                check($sformatf("drain_w%0d", popped), 64'(bus.o_data), 64'(ew));
                popped++;
            end
            @(posedge clk);
            if (acc_now) j++;
        end
        @(negedge clk);
        bus.i_acc_valid = 1'b0;
        bus.i_acc_last  = 1'b0;
        bus.i_ready     = 1'b0;
        check("drain_count", 64'(popped), 64'd16);
        repeat (2) @(negedge clk);
        check("bp_bytes",   64'(bus.o_tile_bytes), 64'd64);
        check("bp_pulses",  64'(tile_pulses - p0), 64'd1);
        check("bp_flags",   64'({bus.o_overflow, bus.o_underflow}), 64'd0);

        // Asynchronous reset mid-tile
        send(32'd7, 1'b0, 5'd0);
        send(32'd9, 1'b0, 5'd0);
        @(negedge clk);
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        check("pre_rst_underflow", 64'(bus.o_underflow), 64'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", 64'(bus.o_acc_ready), 64'd0);
        check("arst_outs",  64'({bus.o_valid, bus.o_underflow, bus.o_overflow, bus.o_tile_done}), 64'd0);
        check("arst_bytes", 64'(bus.o_tile_bytes), 64'd0);
        check("arst_data",  64'(bus.o_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send(32'd10, 1'b0, 5'd0);
        send(32'd20, 1'b0, 5'd0);
        send(32'd30, 1'b0, 5'd0);
        send(32'd40, 1'b0, 5'd0);
        pop_check("post_rst_word", 32'h281E_140A);
        repeat (4) @(negedge clk);
        check("post_rst_single", 64'(bus.o_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire
